led_pulse_stretcher: RTL and testbench

LED_PULSE_STRETCHER -- requirements
Module: led_pulse_stretcher

---
 rtl/led_pulse_stretcher.sv | 121 ++++++++++++
 tb/tb_led_pulse_stretcher.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pulse_stretcher.sv
// Per-channel LED pulse stretcher: each trigger produces an ON_CYCLES blink followed
// by a forced GAP_CYCLES off time. Define LED_PULSE_RETRIGGER_EN to extend a blink on retrigger.
module led_pulse_stretcher #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned ON_CYCLES  = 5_000_000,
    parameter int unsigned GAP_CYCLES = 2_000_000
) (
    input  logic                clock_100mhz,
    input  logic                reset,
    input  logic [CHANNELS-1:0] trigger,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] busy
);

    localparam int unsigned CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t        state_q, state_d;
        logic          pend_q,  pend_d;
        logic [CW-1:0] cnt_q,   cnt_d;
        logic          led_q,   led_d;
        logic          busy_q,  busy_d;

        always_comb begin
            state_d = state_q;
            pend_d  = pend_q;
            cnt_d   = cnt_q;

            case (state_q)
                ST_IDLE: begin
                    if (trigger[g]) begin
                        state_d = ST_ON;
                        cnt_d   = ON_LOAD;
                    end
                end

                ST_ON: begin
`ifdef LED_PULSE_RETRIGGER_EN
                    if (trigger[g]) begin
                        cnt_d = ON_LOAD;
                    end else if (cnt_q == CNT_ONE) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
`else
                    if (trigger[g]) begin
                        pend_d = 1'b1;
                    end
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
`endif
                end

                ST_GAP: begin
                    // A trigger in the last gap cycle counts as pending for this expiry.
                    if (cnt_q == CNT_ONE) begin
                        if (pend_q || trigger[g]) begin
                            state_d = ST_ON;
                            cnt_d   = ON_LOAD;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                        if (trigger[g]) begin
                            pend_d = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase

            led_d  = (state_d == ST_ON);
            busy_d = (state_d != ST_IDLE) || pend_d;
        end

        always_ff @(posedge clock_100mhz) begin
            if (reset) begin
                state_q <= ST_IDLE;
                pend_q  <= 1'b0;
                cnt_q   <= '0;
                led_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                pend_q  <= pend_d;
                cnt_q   <= cnt_d;
                led_q   <= led_d;
                busy_q  <= busy_d;
            end
        end

        assign led[g]  = led_q;
        assign busy[g] = busy_q;
    end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Self-checking bench for led_pulse_stretcher (ON=4, GAP=3, 2 channels) against an
// interval-based blink model; honours LED_PULSE_RETRIGGER_EN when defined.
module tb_led_pulse_stretcher;

    localparam int CH  = 2;
    localparam int ON  = 4;
    localparam int GAP = 3;

    logic          clk;
    logic          reset;
    logic [CH-1:0] trigger;
    logic [CH-1:0] led;
    logic [CH-1:0] busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a blink occupies [m_s, m_e] lit, then [m_e+1, m_e+GAP] dark.
    bit m_act  [CH];
    bit m_pend [CH];
    int m_s    [CH];
    int m_e    [CH];
    int cyc = 0;

    led_pulse_stretcher #(
        .CHANNELS   (CH),
        .ON_CYCLES  (ON),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock_100mhz (clk),
        .reset        (reset),
        .trigger      (trigger),
        .led          (led),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*CH-1:0] expected();
        logic [CH-1:0] l;
        logic [CH-1:0] b;
        for (int ch = 0; ch < CH; ch++) begin
            l[ch] = m_act[ch] && (cyc >= m_s[ch]) && (cyc <= m_e[ch]);
            b[ch] = m_act[ch];
        end
        return {b, l};
    endfunction

    // Drive one cycle's inputs (called at negedge) and advance the model past the next edge.
    task automatic apply(input logic [CH-1:0] t, input logic r);
        trigger = t;
        reset   = r;
        for (int ch = 0; ch < CH; ch++) begin
            if (r) begin
                m_act[ch]  = 1'b0;
                m_pend[ch] = 1'b0;
            end else if (!m_act[ch]) begin
                if (t[ch]) begin
                    m_act[ch] = 1'b1;
                    m_s[ch]   = cyc + 1;
                    m_e[ch]   = cyc + ON;
                end
            end else if (cyc <= m_e[ch]) begin
                if (t[ch]) begin
`ifdef LED_PULSE_RETRIGGER_EN
                    m_e[ch] = cyc + ON;
`else
                    m_pend[ch] = 1'b1;
`endif
                end
            end else begin
                if (t[ch]) m_pend[ch] = 1'b1;
                if (cyc == m_e[ch] + GAP) begin
                    if (m_pend[ch]) begin
                        m_s[ch]    = cyc + 1;
                        m_e[ch]    = cyc + ON;
                        m_pend[ch] = 1'b0;
                    end else begin
                        m_act[ch] = 1'b0;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_act[0] || m_act[1]) && n < 100) begin
            @(negedge clk);
            apply('0, 1'b0);
            n++;
        end
        n_checks++;
        if (m_act[0] || m_act[1]) begin
            n_fail++;
            $display("FAIL wait_idle: model still active after %0d cycles, required idle", n);
        end
        @(negedge clk);
        apply('0, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk); apply('0, 1'b1);
        @(negedge clk); apply(2'b11, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({busy, led} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state: busy,led=%b required 0000", {busy, led});
        end
        apply('0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, led} !== expected()) begin
                n_fail++;
                $display("FAIL reset_idle k=%0d: busy,led=%b required %b", k, {busy, led}, expected());
            end
            apply('0, 1'b0);
        end
    endtask

    task automatic test_single();
        wait_idle();
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, led} !== expected()) begin
                n_fail++;
                $display("FAIL single k=%0d: busy,led=%b required %b", k, {busy, led}, expected());
            end
            if (k == 12 || k == 15) begin
                n_checks++;
                if (led[0] !== (k == 12)) begin
                    n_fail++;
                    $display("FAIL single_led0 k=%0d: led0=%b required %b", k, led[0], k == 12);
                end
            end
            apply((k == 10) ? 2'b01 : 2'b00, 1'b0);
        end
    endtask

    task automatic test_gap_retrigger();
        wait_idle();
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, led} !== expected()) begin
                n_fail++;
                $display("FAIL gap_retrig k=%0d: busy,led=%b required %b", k, {busy, led}, expected());
            end
            apply((k == 10 || k == 16) ? 2'b01 : 2'b00, 1'b0);
        end
    endtask

    task automatic test_on_retrigger();
        wait_idle();
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, led} !== expected()) begin
                n_fail++;
                $display("FAIL on_retrig k=%0d: busy,led=%b required %b", k, {busy, led}, expected());
            end
            apply((k == 10 || k == 12) ? 2'b01 : 2'b00, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        wait_idle();
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, led} !== expected()) begin
                n_fail++;
                $display("FAIL held k=%0d: busy,led=%b required %b", k, {busy, led}, expected());
            end
            apply((k >= 10 && k <= 30) ? 2'b01 : 2'b00, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        logic [CH-1:0] t;
        logic          r;
        wait_idle();
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, led} !== expected()) begin
                n_fail++;
                $display("FAIL reset_mid k=%0d: busy,led=%b required %b", k, {busy, led}, expected());
            end
            if (k == 13) begin
                n_checks++;
                if ({busy, led} !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL reset_mid_clear: busy,led=%b required 0000", {busy, led});
                end
            end
            t = '0;
            r = 1'b0;
            if (k == 10) t = 2'b01;
            if (k == 12) begin t = 2'b10; r = 1'b1; end
            if (k == 13) t = 2'b01;
            apply(t, r);
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] t;
        logic          r;
        int            hold;
        hold = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, led} !== expected()) begin
                n_fail++;
                $display("FAIL random k=%0d: busy,led=%b required %b", k, {busy, led}, expected());
            end
            if (hold == 0 && $urandom_range(0, 40) == 0) hold = $urandom_range(5, 20);
            for (int ch = 0; ch < CH; ch++) t[ch] = ($urandom_range(0, 6) == 0);
            if (hold > 0) begin
                t[0] = 1'b1;
                hold--;
            end
            r = ($urandom_range(0, 120) == 0);
            apply(t, r);
        end
    endtask

    initial begin
        reset   = 1'b1;
        trigger = '0;
        test_reset();
        test_single();
        test_gap_retrigger();
        test_on_retrigger();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
